mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences a multicycle MIPS datapath: one shared ALU, one unified instruction/data memory, instruction register and PC.
- Supports R-type, lw, sw, beq, addi and j; decoding matches the single-cycle main decoder.
- Adds a memory-ready handshake, an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register opcode field and all datapath mux selects and write strobes.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  6  instr[31:26] from instruction register
mem_ready  in  1  memory completes current read/write this cycle
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
PCWrite  out  1  unconditional PC load
Branch  out  1  conditional PC load (datapath ANDs with Zero)
PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
ALUSrcA  out  1  0 = PC, 1 = regA
ALUSrcB  out  2  00 = regB, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
RegDst  out  1  1 = rd, 0 = rt
MemtoReg  out  1  1 = memory data, 0 = ALUOut
RegWrite  out  1  register file write strobe
illegal  out  1  high while in TRAP
state_dbg  out  4  current state encoding
instr_retired  out  CNT_W  count of completed instructions

Behaviour:
- State register is 4 bits. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=15.
- Reset: at a clk edge with rst_n=0, state<=FETCH and instr_retired<=0.
- While rst_n=0, all outputs are forced to 0 combinationally, including strobes, selects and illegal.
- After reset release, the first cycle is FETCH.
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: ALUSrcB=01, and IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcB=11 (branch target precompute).
  - Next state by opcode: 000000→EXECUTE, 100011/101011→MEMADR, 000100→BRANCH, 001000→ADDIEX, 000010→JUMP, any other→TRAP.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10.
  - Next state: lw→MEMRD, sw→MEMWR.
- MEMRD:
  - Outputs: IorD=1.
  - Holds until mem_ready=1, then goes to MEMWB.
- MEMWB:
  - Outputs: MemtoReg=1, RegWrite=1.
  - Next state: FETCH. Retires.
- MEMWR:
  - Outputs: IorD=1, MemWrite=1; MemWrite stays high until mem_ready=1.
  - On mem_ready=1, goes to FETCH. Retires.
- EXECUTE:
  - Outputs: ALUSrcA=1, ALUOp=10.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: RegDst=1, RegWrite=1.
  - Next state: FETCH. Retires.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - Next state: FETCH. Retires.
- ADDIEX:
  - Outputs: ALUSrcA=1, ALUSrcB=10.
  - Next state: ADDIWB.
- ADDIWB:
  - Outputs: RegWrite=1.
  - Next state: FETCH. Retires.
- JUMP:
  - Outputs: PCSrc=10, PCWrite=1.
  - Next state: FETCH. Retires.
- TRAP:
  - Outputs: illegal=1; all strobes are 0.
  - Holds until reset. Unused encodings 12–14 go to TRAP.
- Retire: instr_retired increments by 1 on the edge leaving a retiring state toward FETCH. It wraps from all-ones to 0.
- Latencies with mem_ready tied to 1:
  - R-type: 4 cycles. addi: 4. lw: 5. sw: 4. beq: 3. j: 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- opcode is sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- Reset mid-instruction: all strobes drop in the same cycle rst_n falls. A partially executed sw issues no further MemWrite.

Test Plan:
- rst_n=0 for 2 cycles with opcode=100011 and mem_ready=1 → all outputs 0. After release, state_dbg=0 and IRWrite=PCWrite=1 in the first cycle.
- R-type (000000), mem_ready=1 → state_dbg sequence 0,1,6,7,0. RegWrite=RegDst=1 only in ALUWB. instr_retired=1.
- lw (100011) with mem_ready low for 3 cycles in MEMRD → sequence 0,1,2,3,3,3,3,4,0 (3 wait cycles plus the ready cycle in MEMRD). MemtoReg=RegWrite=1 only in MEMWB.
- sw (101011) with mem_ready low for 2 cycles in MEMWR → MemWrite=1 and IorD=1 for 3 consecutive cycles, then FETCH. RegWrite is never asserted.
- Sequence beq then j → beq: Branch=1, PCSrc=01 in state 8. j: PCWrite=1, PCSrc=10 in state 11. instr_retired increments by 2.
- opcode=111111 in DECODE → state 15 and illegal=1 held for 10 cycles regardless of opcode. rst_n=0 returns to FETCH.
- CNT_W=4, 17 R-type instructions → instr_retired=1 (wrap).
- rst_n falls during MEMWR → MemWrite=0 in the same cycle; state_dbg=0 after the edge.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared ALU / unified memory datapath,
// with memory-ready handshake, illegal-opcode trap and retired-instruction counter.
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             illegal,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    TRAP    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state;
  state_t           state_nxt;
  logic             retire;
  logic [CNT_W-1:0] cnt;

  // Next-state and retire decode
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      FETCH:   if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
          default:      state_nxt = TRAP;
        endcase
      end
      MEMADR: begin
        case (opcode)
          OP_LW:   state_nxt = MEMRD;
          OP_SW:   state_nxt = MEMWR;
          default: state_nxt = TRAP;
        endcase
      end
      MEMRD:   if (mem_ready) state_nxt = MEMWB;
      MEMWR: begin
        if (mem_ready) begin
          state_nxt = FETCH;
          retire    = 1'b1;
        end
      end
      EXECUTE: state_nxt = ALUWB;
      ADDIEX:  state_nxt = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  // Datapath controls; everything is held low while reset is asserted
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    illegal  = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE:  ALUSrcB = 2'b11;
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD:   IorD = 1'b1;
        MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b01;
          PCSrc   = 2'b01;
          Branch  = 1'b1;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ADDIWB:  RegWrite = 1'b1;
        JUMP: begin
          PCSrc   = 2'b10;
          PCWrite = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign state_dbg     = rst_n ? 4'(state) : 4'd0;
  assign instr_retired = rst_n ? cnt : '0;

endmodule
